// File: rtl/sync_fifo_read_ctrl.sv
// sync_fifo_read_ctrl: head pointer, storage read strobe and valid/ready output stage of the synchronous FIFO
module sync_fifo_read_ctrl #(
    parameter int DATA_WIDTH       = 64,
    parameter int NUM_FIFO_BLOCKS  = 1024,
    parameter int POINTER_NUM_BITS = $clog2(NUM_FIFO_BLOCKS)
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [POINTER_NUM_BITS:0]   wr_ptr_i,
    output logic [POINTER_NUM_BITS:0]   rd_ptr_o,
    output logic                        rd_req_o,
    output logic [POINTER_NUM_BITS-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0]       rd_data_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        empty_o,
    output logic [POINTER_NUM_BITS:0]   fill_level_o,
    output logic                        err_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, PRESENT = 2'd2} state_t;
    localparam logic [POINTER_NUM_BITS:0] FULL_LVL = (POINTER_NUM_BITS+1)'(NUM_FIFO_BLOCKS);
    localparam logic [POINTER_NUM_BITS:0] PTR_ONE  = (POINTER_NUM_BITS+1)'(1);
    state_t                      state_q, state_d;
    logic [POINTER_NUM_BITS:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic                        err_q, err_d;
    logic                        corrupt;
    assign fill_level_o = wr_ptr_i - rd_ptr_q;
    assign empty_o      = wr_ptr_i == rd_ptr_q;
    assign corrupt      = fill_level_o > FULL_LVL;
    // No strobe during reset or while the pointer pair is inconsistent, even before err_q registers it
    assign rd_req_o     = rst_n_i && !err_q && !corrupt && !empty_o &&
                          (state_q == IDLE || (state_q == PRESENT && ready_i));
    assign rd_ptr_o     = rd_ptr_q;
    assign rd_addr_o    = rd_ptr_q[POINTER_NUM_BITS-1:0];
    assign data_o       = data_q;
    assign valid_o      = state_q == PRESENT;
    assign err_o        = err_q;
    always_comb begin
        state_d  = state_q == WAIT ? PRESENT :
                   rd_req_o ? WAIT :
                   (state_q == PRESENT && !ready_i) ? PRESENT : IDLE;
        rd_ptr_d = rd_req_o ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        data_d   = state_q == WAIT ? rd_data_i : data_q;
        err_d    = err_q | corrupt;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_sync_fifo_read_ctrl.sv
// tb_sync_fifo_read_ctrl: directed vector table plus hand sequences for wrap, corruption and reset-in-WAIT
module tb_sync_fifo_read_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic       rd_req;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       empty;
    logic [2:0] fill;
    logic       err;
    logic [7:0] mem [4];
    int checks = 0;
    int failures = 0;

    sync_fifo_read_ctrl #(.DATA_WIDTH(8), .NUM_FIFO_BLOCKS(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .wr_ptr_i(wr_ptr), .rd_ptr_o(rd_ptr),
        .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .data_o(data), .valid_o(valid), .ready_i(ready), .empty_o(empty),
        .fill_level_o(fill), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_req) rd_data <= mem[rd_addr];

    typedef struct {
        logic       rst_n;
        logic [2:0] wr;
        logic       rdy;
        logic       req;
        logic [2:0] ptr;
        logic       vld;
        logic [7:0] dat;
        logic       emp;
        logic [2:0] fill;
        logic       err;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] w, input logic y, input logic q,
                       input logic [2:0] p, input logic v, input logic [7:0] d,
                       input logic e, input logic [2:0] f, input logic x);
        vecs.push_back('{r, w, y, q, p, v, d, e, f, x});
    endtask

    initial begin
        logic [7:0] addrs[$];
        logic [7:0] datas[$];
        logic [2:0] wrp;
        int sent;
        bit saw7;
        bit saw_wrap;
        mem[0] = 8'hA5; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        rd_data = '0;
        rst_n = 1'b0; wr_ptr = 3'd5; ready = 1'b0;
        repeat (2) @(posedge clk);
        //  rst wr  rdy | req ptr vld dat    emp fill err
        add(0, 5, 0,    0, 0, 0, 8'h00, 0, 5, 0);
        add(0, 0, 0,    0, 0, 0, 8'h00, 1, 0, 0);
        add(1, 0, 1,    0, 0, 0, 8'h00, 1, 0, 0);
        add(1, 1, 1,    1, 0, 0, 8'h00, 0, 1, 0);
        add(1, 1, 1,    0, 1, 0, 8'h00, 1, 0, 0);
        add(1, 1, 1,    0, 1, 1, 8'hA5, 1, 0, 0);
        add(1, 1, 1,    0, 1, 0, 8'hA5, 1, 0, 0);
        add(1, 4, 0,    1, 1, 0, 8'hA5, 0, 3, 0);
        add(1, 4, 0,    0, 2, 0, 8'hA5, 0, 2, 0);
        for (int i = 0; i < 10; i++) add(1, 4, 0, 0, 2, 1, 8'h11, 0, 2, 0);
        add(1, 4, 1,    1, 2, 1, 8'h11, 0, 2, 0);
        add(1, 4, 1,    0, 3, 0, 8'h11, 0, 1, 0);
        add(1, 4, 1,    1, 3, 1, 8'h22, 0, 1, 0);
        add(1, 4, 1,    0, 4, 0, 8'h22, 1, 0, 0);
        add(1, 4, 1,    0, 4, 1, 8'h33, 1, 0, 0);
        add(1, 4, 1,    0, 4, 0, 8'h33, 1, 0, 0);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; wr_ptr = vecs[i].wr; ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d.rd_req", i), rd_req, vecs[i].req);
            chk($sformatf("vec%0d.rd_ptr", i), rd_ptr, vecs[i].ptr);
            chk($sformatf("vec%0d.rd_addr", i), rd_addr, vecs[i].ptr[1:0]);
            chk($sformatf("vec%0d.valid", i), valid, vecs[i].vld);
            chk($sformatf("vec%0d.data", i), data, vecs[i].dat);
            chk($sformatf("vec%0d.empty", i), empty, vecs[i].emp);
            chk($sformatf("vec%0d.fill", i), fill, vecs[i].fill);
            chk($sformatf("vec%0d.err", i), err, vecs[i].err);
        end

        // streaming across the pointer wrap, producer never overfills
        wrp = 3'd4; sent = 0; saw7 = 0; saw_wrap = 0;
        for (int cyc = 0; cyc < 80 && datas.size() < 10; cyc++) begin
            @(negedge clk);
            if (sent < 10 && 3'(wrp - rd_ptr) != 3'd4) begin
                mem[wrp[1:0]] = 8'h40 + 8'(sent);
                wrp = wrp + 3'd1;
                sent++;
            end
            wr_ptr = wrp; ready = 1'b1;
            #1;
            if (rd_req) addrs.push_back({6'd0, rd_addr});
            if (valid && ready) datas.push_back(data);
            if (rd_ptr == 3'd7) saw7 = 1;
            if (saw7 && rd_ptr == 3'd0) saw_wrap = 1;
        end
        chk("wrap.reads", addrs.size(), 10);
        chk("wrap.words", datas.size(), 10);
        for (int i = 0; i < 10 && i < addrs.size(); i++) chk($sformatf("wrap.addr%0d", i), addrs[i], i % 4);
        for (int i = 0; i < 10 && i < datas.size(); i++) chk($sformatf("wrap.data%0d", i), datas[i], 8'h40 + i);
        chk("wrap.ptr7to0", saw_wrap, 1);
        @(negedge clk); #1;
        chk("wrap.final_ptr", rd_ptr, 6);
        chk("wrap.final_empty", empty, 1);

        // exactly full is legal
        @(negedge clk); rst_n = 1'b0; wr_ptr = 3'd0; ready = 1'b0;
        @(negedge clk); rst_n = 1'b1; wr_ptr = 3'd4;
        #1;
        chk("full.fill", fill, 4);
        chk("full.empty", empty, 0);
        chk("full.rd_req", rd_req, 1);
        @(negedge clk); #1;
        chk("full.err", err, 0);

        // corruption: fill beyond capacity latches err until reset
        @(negedge clk); rst_n = 1'b0; wr_ptr = 3'd0;
        @(negedge clk); rst_n = 1'b1; wr_ptr = 3'd5;
        #1;
        chk("corrupt.fill", fill, 5);
        chk("corrupt.err_before", err, 0);
        chk("corrupt.rd_req_now", rd_req, 0);
        @(negedge clk); #1;
        chk("corrupt.err_set", err, 1);
        wr_ptr = 3'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk($sformatf("corrupt.err_sticky%0d", i), err, 1);
            chk($sformatf("corrupt.no_req%0d", i), rd_req, 0);
            chk($sformatf("corrupt.ptr%0d", i), rd_ptr, 0);
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; wr_ptr = 3'd0;
        #1;
        chk("corrupt.err_cleared", err, 0);

        // reset while the read is in flight
        mem[0] = 8'h77;
        @(negedge clk); wr_ptr = 3'd1; ready = 1'b1;
        #1;
        chk("rstwait.rd_req", rd_req, 1);
        chk("rstwait.rd_addr", rd_addr, 0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("rstwait.valid_wait", valid, 0);
        @(negedge clk); rst_n = 1'b1; wr_ptr = 3'd0;
        #1;
        chk("rstwait.valid", valid, 0);
        chk("rstwait.data", data, 0);
        chk("rstwait.ptr", rd_ptr, 0);
        chk("rstwait.rd_req_empty", rd_req, 0);
        @(negedge clk); wr_ptr = 3'd1;
        #1;
        chk("rstwait.idle_req", rd_req, 1);
        chk("rstwait.idle_valid", valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
